redirect_req_arbiter: RTL and testbench

//  Shares one redirect_mop resource between N_REQ requesters wanting an initiator redirect.
//  - Round-robin arbitration among pending requests; latches the winner's (source, target) IDs.
//  - Issues a one-cycle valid to the resource and waits for its completion valid, under a timeout.
//  - Reports done/error per requester. Sits between the REG_BUS-facing test/config wrappers and
//    the redirect_mop instance; lock_i (from reglk_ctrl) freezes new grants.

---
 rtl/redirect_arb_pkg.sv | 6 +
 rtl/redirect_req_arbiter_rr_pick.sv | 22 ++
 rtl/redirect_req_arbiter.sv | 108 ++++++++++
 tb/tb_redirect_req_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/redirect_arb_pkg.sv
// redirect_arb_pkg: shared FSM state encoding and counter sizing for the redirect request arbiter.
package redirect_arb_pkg;
    typedef enum logic [2:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP, ARB_REJ} arb_state_e;
    localparam int ARB_TIMEOUT = 16;
    localparam int ARB_CNT_W = $clog2(ARB_TIMEOUT);
endpackage

// File: rtl/redirect_req_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first valid request at or after ptr_i (wrapping).
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [PW-1:0] grant_o,
    output logic          any_o
);
    // Scan from the farthest offset down so the closest one to ptr_i wins.
    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % N]) begin
                grant_o = PW'((int'(ptr_i) + k) % N);
                any_o   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/redirect_req_arbiter.sv
// redirect_req_arbiter: round-robin sharing of one redirect_mop between N_REQ requesters,
// with issue strobe, completion wait under timeout, and per-requester done/err pulses.
module redirect_req_arbiter
    import redirect_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int LOG_N_INIT = 3,
    parameter int TIMEOUT    = ARB_TIMEOUT,
    parameter int GW         = $clog2(N_REQ)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [N_REQ-1:0]            req_valid_i,
    input  logic [N_REQ*LOG_N_INIT-1:0] req_src_i,
    input  logic [N_REQ*LOG_N_INIT-1:0] req_tgt_i,
    output logic [N_REQ-1:0]            req_ready_o,
    output logic [N_REQ-1:0]            done_o,
    output logic [N_REQ-1:0]            err_o,
    input  logic                        lock_i,
    output logic                        mop_valid_o,
    output logic [LOG_N_INIT-1:0]       mop_request_o,
    output logic [LOG_N_INIT-1:0]       mop_receive_o,
    input  logic                        mop_valid_i,
    output logic                        busy_o,
    output logic [GW-1:0]               grant_id_o
);
    localparam int CNT_W = $clog2(TIMEOUT);
    arb_state_e            state_q, state_d;
    logic [GW-1:0]         ptr_q, ptr_d, g_q, g_d, pick_g;
    logic [LOG_N_INIT-1:0] src_q, src_d, tgt_q, tgt_d, pick_src, pick_tgt;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ok_q, ok_d, pick_any, accept;

    rr_pick #(.N(N_REQ), .PW(GW)) u_pick (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (pick_g),
        .any_o   (pick_any)
    );

    assign pick_src = req_src_i[pick_g*LOG_N_INIT +: LOG_N_INIT];
    assign pick_tgt = req_tgt_i[pick_g*LOG_N_INIT +: LOG_N_INIT];
    // Reset also masks the combinational ready so every output reads 0 while held.
    assign accept   = rst_ni && state_q == ARB_IDLE && pick_any && !lock_i;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        src_d   = src_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        ok_d    = ok_q;
        case (state_q)
            ARB_IDLE: if (accept) begin
                g_d     = pick_g;
                src_d   = pick_src;
                tgt_d   = pick_tgt;
                ptr_d   = GW'((int'(pick_g) + 1) % N_REQ);
                state_d = (pick_src == pick_tgt) ? ARB_REJ : ARB_ISSUE;
            end
            ARB_ISSUE: begin
                cnt_d   = '0;
                state_d = ARB_WAIT;
            end
            // Completion takes priority over a timeout in the same cycle.
            ARB_WAIT: if (mop_valid_i) begin
                ok_d    = 1'b1;
                state_d = ARB_RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                ok_d    = 1'b0;
                state_d = ARB_RESP;
            end else begin
                cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            src_q   <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            src_q   <= src_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            ok_q    <= ok_d;
        end
    end

    assign req_ready_o   = accept ? N_REQ'(1) << pick_g : '0;
    assign done_o        = (state_q == ARB_RESP && ok_q) ? N_REQ'(1) << g_q : '0;
    assign err_o         = ((state_q == ARB_RESP && !ok_q) || state_q == ARB_REJ) ? N_REQ'(1) << g_q : '0;
    assign mop_valid_o   = state_q == ARB_ISSUE;
    assign mop_request_o = src_q;
    assign mop_receive_o = tgt_q;
    assign busy_o        = state_q != ARB_IDLE;
    assign grant_id_o    = g_q;
endmodule

// File: tb/tb_redirect_req_arbiter.sv
// tb_redirect_req_arbiter: directed checks of grant order, latency, timeout, reject, lock and reset.
module tb_redirect_req_arbiter;
    localparam int N = 4;
    localparam int W = 3;
    localparam int TO = 16;
    logic clk_i = 1'b0;
    logic rst_ni;
    logic [N-1:0] req_valid_i, req_ready_o, done_o, err_o;
    logic [N*W-1:0] req_src_i, req_tgt_i;
    logic lock_i, mop_valid_o, mop_valid_i, busy_o;
    logic [W-1:0] mop_request_o, mop_receive_o;
    logic [1:0] grant_id_o;
    int total = 0;
    int passed = 0;
    logic flag;

    redirect_req_arbiter #(.N_REQ(N), .LOG_N_INIT(W), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_src_i(req_src_i),
        .req_tgt_i(req_tgt_i), .req_ready_o(req_ready_o), .done_o(done_o), .err_o(err_o),
        .lock_i(lock_i), .mop_valid_o(mop_valid_o), .mop_request_o(mop_request_o),
        .mop_receive_o(mop_receive_o), .mop_valid_i(mop_valid_i), .busy_o(busy_o),
        .grant_id_o(grant_id_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst_ni = 1'b0; req_valid_i = '0; lock_i = 1'b0; mop_valid_i = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_src_i[i*W +: W] = W'(i);
            req_tgt_i[i*W +: W] = W'(i + 4);
        end
        tick(); tick();
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_outs", {req_ready_o, done_o, err_o, mop_valid_o, mop_request_o, mop_receive_o, grant_id_o}, 0);
        rst_ni = 1'b1;
        // single request with hand-picked IDs
        req_src_i[1*W +: W] = 3'd3; req_tgt_i[1*W +: W] = 3'd5;
        req_valid_i = 4'b0010; #1;
        chk("t1_ready", 32'(req_ready_o), 4'b0010);
        tick(); req_valid_i = '0;
        chk("t1_issue", {mop_valid_o, mop_request_o, mop_receive_o, grant_id_o}, {1'b1, 3'd3, 3'd5, 2'd1});
        tick();
        chk("t1_one_shot", 32'(mop_valid_o), 0);
        tick(); tick(); mop_valid_i = 1'b1;
        tick(); mop_valid_i = 1'b0;
        chk("t1_done", {done_o, err_o}, {4'b0010, 4'b0000});
        tick();
        chk("t1_idle", {busy_o, done_o}, 0);
        req_src_i[1*W +: W] = 3'd1; req_tgt_i[1*W +: W] = 3'd5;
        // fairness from a fresh pointer
        rst_ni = 1'b0; tick(); rst_ni = 1'b1;
        req_valid_i = 4'b1111; #1;
        for (int k = 0; k < 5; k++) begin
            chk("t2_ready", 32'(req_ready_o), 32'(4'b0001 << (k % 4)));
            tick();
            chk("t2_issue", {mop_valid_o, mop_request_o}, {1'b1, 3'(k % 4)});
            tick(); tick(); mop_valid_i = 1'b1;
            tick(); mop_valid_i = 1'b0;
            chk("t2_done", 32'(done_o), 32'(4'b0001 << (k % 4)));
            tick();
        end
        req_valid_i = '0;
        // timeout: ptr is 1 so request 2 is picked directly
        req_valid_i = 4'b0100; #1;
        chk("t3_ready", 32'(req_ready_o), 4'b0100);
        tick(); req_valid_i = '0;
        chk("t3_issue", 32'(mop_valid_o), 1);
        flag = 1'b0;
        for (int k = 0; k < TO; k++) begin
            tick();
            flag = flag | (|err_o) | (|done_o);
        end
        chk("t3_no_early_err", 32'(flag), 0);
        tick();
        chk("t3_err", {err_o, done_o}, {4'b0100, 4'b0000});
        tick();
        // completion on the last wait cycle still counts as done; ptr is 3 so this wraps to 2
        req_valid_i = 4'b0100; #1;
        chk("t3b_ready", 32'(req_ready_o), 4'b0100);
        tick(); req_valid_i = '0;
        for (int k = 0; k < TO - 1; k++) tick();
        tick(); mop_valid_i = 1'b1;
        tick(); mop_valid_i = 1'b0;
        chk("t3b_done", {done_o, err_o}, {4'b0100, 4'b0000});
        tick();
        // reject on src == tgt
        req_src_i[2*W +: W] = 3'd7; req_tgt_i[2*W +: W] = 3'd7;
        req_valid_i = 4'b0100; #1;
        chk("t4_ready", 32'(req_ready_o), 4'b0100);
        tick(); req_valid_i = '0;
        chk("t4_err", {err_o, done_o, mop_valid_o}, {4'b0100, 4'b0000, 1'b0});
        tick();
        chk("t4_idle", {busy_o, err_o, mop_valid_o}, 0);
        req_src_i[2*W +: W] = 3'd2; req_tgt_i[2*W +: W] = 3'd6;
        // lock holds off grants; ptr is 3
        lock_i = 1'b1; req_valid_i = 4'b1111;
        flag = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            flag = flag | (|req_ready_o) | busy_o;
        end
        chk("t5_locked", 32'(flag), 0);
        lock_i = 1'b0; #1;
        chk("t5_ready_ptr", 32'(req_ready_o), 4'b1000);
        tick(); lock_i = 1'b1;
        chk("t5_issue", {mop_valid_o, mop_request_o}, {1'b1, 3'd3});
        tick(); tick(); mop_valid_i = 1'b1;
        tick(); mop_valid_i = 1'b0;
        chk("t5_done_locked", 32'(done_o), 4'b1000);
        tick();
        chk("t5_still_locked", {busy_o, req_ready_o}, 0);
        lock_i = 1'b0; #1;
        chk("t5_after_unlock", 32'(req_ready_o), 4'b0001);
        // reset in WAIT
        tick(); req_valid_i = '0;
        tick(); tick();
        chk("t6_in_wait", 32'(busy_o), 1);
        rst_ni = 1'b0; tick();
        chk("t6_rst_outs", {busy_o, req_ready_o, done_o, err_o, mop_valid_o, mop_request_o, mop_receive_o, grant_id_o}, 0);
        rst_ni = 1'b1; mop_valid_i = 1'b1;
        tick(); mop_valid_i = 1'b0;
        chk("t6_late_mop", {done_o, err_o, busy_o}, 0);
        req_valid_i = 4'b1111; #1;
        chk("t6_ptr0", 32'(req_ready_o), 4'b0001);
        req_valid_i = '0;
        tick(); tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
